// File: rtl/glyph_pkg.sv
// Shared constants and state type for the glyph ROM row reader.
// Geometry: 128 one-bit ROM addresses folded into 16 rows of 8 pixels.
package glyph_pkg;

    localparam int ADDR_W    = 7;
    localparam int ROW_W     = 8;
    localparam int ROWS      = (1 << ADDR_W) / ROW_W;
    localparam int ROW_IDX_W = $clog2(ROWS);
    localparam int COL_W     = $clog2(ROW_W);
    localparam int CNT_W     = COL_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } reader_state_t;

endpackage

// File: rtl/glyph_row_shifter.sv
// Row capture register: inserts ROM bits by column and publishes the finished word.
// Define GLYPH_ROW_MIRROR_EN to pack column c into bit c (mirrored glyph) instead of MSB-first.
module glyph_row_shifter
    import glyph_pkg::*;
(
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             insert,
    input  logic [COL_W-1:0] col,
    input  logic             bit_in,
    input  logic             commit,
    output logic [ROW_W-1:0] row_data
);

    logic [ROW_W-1:0] work;
    logic [COL_W-1:0] pos;

`ifdef GLYPH_ROW_MIRROR_EN
    assign pos = col;
`else
    // Column 0 is the leftmost pixel, which lands in the MSB.
    assign pos = COL_W'(ROW_W - 1) - col;
`endif

    // The working word fills in the background; row_data only changes on commit,
    // so the consumer keeps seeing the last delivered row while the next one loads.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            work     <= '0;
            row_data <= '0;
        end else begin
            if (clear) begin
                work <= '0;
            end else if (insert) begin
                work[pos] <= bit_in;
            end
            if (commit) begin
                row_data <= work;
            end
        end
    end

endmodule

// File: rtl/glyph_row_reader.sv
// Sweeps a 1-bit glyph ROM and hands out packed row words over valid/ready.
// Packing order is selected in glyph_row_shifter by GLYPH_ROW_MIRROR_EN.
module glyph_row_reader
    import glyph_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_W-1:0]    rom_address,
    input  logic                 rom_q,
    output logic [ROW_W-1:0]     row_data,
    output logic [ROW_IDX_W-1:0] row_idx,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 busy,
    output logic                 done
);

    reader_state_t          state;
    reader_state_t          next_state;
    logic [ROW_IDX_W-1:0]   row_cnt;
    logic [ROW_IDX_W-1:0]   row_next;
    logic [CNT_W-1:0]       issue_cnt;
    logic [CNT_W-1:0]       cap_cnt;
    logic [1:0]             pend;
    logic                   issuing;
    logic                   last_row;
    logic                   start_sweep;
    logic                   transfer;
    logic                   complete;
    logic                   insert;

    assign issuing  = (issue_cnt < CNT_W'(ROW_W));
    assign last_row = (row_cnt == ROW_IDX_W'(ROWS - 1));
    assign row_next = row_cnt + 1'b1;
    assign insert   = (state == FETCH) && pend[1];
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Row completion is detected one edge after the last capture, which gives
    // the ROW_W+2 start-to-valid latency and ROW_W+3 cycles per row at full rate.
    always_comb begin
        next_state  = state;
        start_sweep = 1'b0;
        transfer    = 1'b0;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_sweep = 1'b1;
                    next_state  = FETCH;
                end
            end
            FETCH: begin
                if (cap_cnt == CNT_W'(ROW_W)) begin
                    complete   = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (row_ready) begin
                    transfer   = 1'b1;
                    next_state = last_row ? DONE : FETCH;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // pend[0] marks an address presented this cycle, pend[1] marks ROM data
    // arriving on rom_q; captures are in issue order so cap_cnt is the column.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rom_address <= '0;
            row_cnt     <= '0;
            issue_cnt   <= '0;
            cap_cnt     <= '0;
            pend        <= '0;
            row_valid   <= 1'b0;
            row_idx     <= '0;
        end else if (start_sweep) begin
            rom_address <= '0;
            row_cnt     <= '0;
            issue_cnt   <= CNT_W'(1);
            cap_cnt     <= '0;
            pend        <= 2'b01;
        end else if (transfer) begin
            row_valid <= 1'b0;
            if (last_row) begin
                rom_address <= '0;
                pend        <= '0;
            end else begin
                rom_address <= {row_next, {COL_W{1'b0}}};
                row_cnt     <= row_next;
                issue_cnt   <= CNT_W'(1);
                cap_cnt     <= '0;
                pend        <= 2'b01;
            end
        end else if (complete) begin
            row_valid <= 1'b1;
            row_idx   <= row_cnt;
            pend      <= '0;
        end else if (state == FETCH) begin
            if (issuing) begin
                rom_address <= rom_address + 1'b1;
                issue_cnt   <= issue_cnt + 1'b1;
            end
            pend <= {pend[0], issuing};
            if (pend[1]) begin
                cap_cnt <= cap_cnt + 1'b1;
            end
        end
    end

    glyph_row_shifter u_shifter (
        .clock    (clock),
        .rst_n    (rst_n),
        .clear    (start_sweep | transfer),
        .insert   (insert),
        .col      (cap_cnt[COL_W-1:0]),
        .bit_in   (rom_q),
        .commit   (complete),
        .row_data (row_data)
    );

endmodule

// File: tb/tb_glyph_row_reader.sv
// Directed bench for glyph_row_reader against a registered ROM_0 model.
// Expected rows follow GLYPH_ROW_MIRROR_EN when it is defined for the build.
module tb_glyph_row_reader;

    logic       clock;
    logic       rst_n;
    logic       start;
    logic [6:0] rom_address;
    logic       rom_q;
    logic [7:0] row_data;
    logic [3:0] row_idx;
    logic       row_valid;
    logic       row_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] rowsRef [16] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h66, 8'h43, 8'hC3, 8'hC3,
                                 8'hC3, 8'hC3, 8'hC3, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00};
    logic       romBits [128];

    glyph_row_reader dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM model: registered q, one cycle of read latency, no reset.
    always @(posedge clock) rom_q <= romBits[rom_address];

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] expRow(input int r);
        logic [7:0] w;
        logic [7:0] m;
        w = rowsRef[r];
`ifdef GLYPH_ROW_MIRROR_EN
        for (int i = 0; i < 8; i++) m[i] = w[7 - i];
`else
        m = w;
`endif
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rdy);
        @(negedge clock);
        start     = st;
        row_ready = rdy;
    endtask

    // Pulses start, then follows one sweep to its done pulse, optionally stalling
    // one row for 7 cycles or poking start while a given row is being fetched.
    task automatic runSweep(input int stallRow, input int pokeRow);
        int  rowsSeen = 0;
        int  doneSeen = 0;
        int  firstAt  = -1;
        int  k        = 0;
        bit  poked    = 0;
        bit  finished = 0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        while (!finished && k < 400) begin
            @(negedge clock);
            k++;
            if (pokeRow >= 0) begin
                start = (rowsSeen == pokeRow) && !poked && !row_valid;
                if (start) poked = 1;
            end
            if (done) doneSeen++;
            if (row_valid) begin
                if (firstAt < 0) firstAt = k;
                if (rowsSeen == stallRow) begin
                    row_ready = 1'b0;
                    repeat (7) begin
                        @(negedge clock);
                        k++;
                        checkOutput("stall_valid", row_valid, 1);
                        checkOutput("stall_data", row_data, expRow(stallRow));
                        checkOutput("stall_idx", row_idx, stallRow);
                        checkOutput("stall_addr", rom_address, stallRow * 8 + 7);
                    end
                    row_ready = 1'b1;
                end
                checkOutput("row_data", row_data, expRow(rowsSeen));
                checkOutput("row_idx", row_idx, rowsSeen);
                rowsSeen++;
            end
            if (doneSeen > 0 && !busy) finished = 1;
        end
        start = 1'b0;
        checkOutput("first_valid_latency", firstAt, 10);
        checkOutput("rows_delivered", rowsSeen, 16);
        checkOutput("done_pulses", doneSeen, 1);
        checkOutput("busy_after", busy, 0);
        checkOutput("addr_after", rom_address, 0);
    endtask

    initial begin
        int seen;
        int k;
        for (int a = 0; a < 128; a++) romBits[a] = rowsRef[a / 8][7 - (a % 8)];
        rst_n     = 1'b0;
        start     = 1'b0;
        row_ready = 1'b0;

        repeat (3) @(negedge clock);
        checkOutput("rst_addr", rom_address, 0);
        checkOutput("rst_data", row_data, 0);
        checkOutput("rst_idx", row_idx, 0);
        checkOutput("rst_valid", row_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("idle_addr_busy", {rom_address, busy}, 0);
        end

        $display("[TB] full sweep, ready tied high");
        runSweep(-1, -1);
        $display("[TB] backpressure on row 4");
        runSweep(4, -1);
        $display("[TB] start poked during row 2");
        runSweep(-1, 2);

        $display("[TB] reset during fetch of row 6");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        seen = 0;
        k    = 0;
        while (seen < 6 && k < 200) begin
            @(negedge clock);
            k++;
            if (row_valid) seen++;
        end
        repeat (3) @(negedge clock);
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_valid", row_valid, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_addr", rom_address, 0);
        checkOutput("mid_rst_data", row_data, 0);
        checkOutput("mid_rst_idx", row_idx, 0);
        checkOutput("mid_rst_valid", row_valid, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        @(negedge clock);
        rst_n = 1'b1;
        runSweep(-1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_row_reader.md
Name: glyph_row_reader

Overview:
- Reader side of the 1-bit glyph ROMs: 128 addresses, 7-bit address, registered 1-bit q, one-cycle read latency.
- Sweeps the ROM address space row by row and packs ROW_W consecutive bits into one row word.
- Hands each row word to the display/scan logic over a valid/ready handshake.
- Sits between the ROM_n instances and the pixel/row driver.

Parameters:
- ADDR_W, 7: ROM address width; depth = 2^ADDR_W.
- ROW_W, 8: bits per row word; must divide 2^ADDR_W.
- Derived: ROWS = 2^ADDR_W / ROW_W = 16; ROW_IDX_W = log2(ROWS) = 4.

Ports:
- clock, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: begin a full glyph sweep; sampled only in IDLE.
- rom_address, out, ADDR_W: address to ROM, registered.
- rom_q, in, 1: ROM data, valid one clock after address is sampled by ROM.
- row_data, out, ROW_W: packed row word.
- row_idx, out, ROW_IDX_W: index of row_data row.
- row_valid, out, 1: row_data/row_idx valid.
- row_ready, in, 1: consumer accepts row.
- busy, out, 1: high in any state except IDLE.
- done, out, 1: one-cycle pulse after last row accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0, including rom_address, row_data, row_idx, row_valid, busy and done.
- States: IDLE, FETCH, HOLD, DONE.
- IDLE -> FETCH when start=1 at an edge.
  - At that edge: rom_address <= 0, row counter <= 0, issue counter <= 1, capture counter <= 0.
- FETCH:
  - rom_address increments each edge until ROW_W addresses of the current row are issued, then holds.
  - Bit issued at address A reaches rom_q after the ROM edge; the reader captures it at the following edge (2 edges after rom_address=A is registered).
  - A 2-deep issue-valid shift pipeline tracks outstanding reads.
  - Column c = A mod ROW_W is packed into row_data[ROW_W-1-c] (MSB = leftmost pixel).
  - When the ROW_W-th bit is captured: -> HOLD, row_valid <= 1, row_idx <= row counter.
  - First row_valid rises ROW_W+2 = 10 edges after the start edge.
- HOLD:
  - row_data, row_idx and rom_address stay stable while row_valid=1 and row_ready=0.
  - Transfer occurs at an edge with row_valid and row_ready both 1; row_ready may be high before row_valid.
  - On transfer with rows remaining: row_valid <= 0, rom_address <= (row+1)*ROW_W, row counter increments, state -> FETCH.
  - On transfer of row ROWS-1: row_valid <= 0, rom_address <= 0, state -> DONE.
- DONE: done=1 for exactly one cycle, busy=1, then -> IDLE.
- Boundaries:
  - start in FETCH, HOLD or DONE is ignored; no restart, no queueing.
  - start held high continuously yields back-to-back sweeps with one IDLE cycle between.
  - rom_address never wraps past 2^ADDR_W-1 within a sweep.
  - Max-rate throughput is one row per ROW_W+3 cycles.
  - rst_n asserted mid-sweep aborts immediately: no done pulse, and the partial row is discarded.
  - row_data holds the last transferred word until the next row completes; it is cleared only by reset.

Optional Feature:
- Macro: GLYPH_ROW_MIRROR_EN.
- Defined: column c packs into row_data[c], giving a horizontally mirrored glyph; all timing identical.
- Undefined: MSB-first packing as above.

Decomposition:
- Shared package glyph_pkg:
  - ADDR_W and ROW_W defaults.
  - ROWS and ROW_IDX_W constants.
  - State enum type reader_state_t {IDLE, FETCH, HOLD, DONE}.
- Sub-module glyph_row_shifter: ROW_W-bit capture register with column-indexed bit insert, clear and mirror option.
  - It carries the GLYPH_ROW_MIRROR_EN switch, so the FSM stays free of packing logic.

Test Plan:
- Reset/idle: rst_n low 3 cycles, start=0 -> all outputs 0; rom_address=0 and busy=0 for 20 cycles.
- Full sweep, ROM_0 model, row_ready tied 1: start pulse -> first row_valid exactly 10 edges later.
  - Row sequence 0x00,0x00,0x00,0x3C,0x66,0x43,0xC3,0xC3,0xC3,0xC3,0xC3,0x66,0x3C,0x00,0x00,0x00 with row_idx 0..15.
  - Then one done pulse, then busy=0.
- Backpressure: row_ready low for 7 cycles when row 4 is presented -> row_data=0x66, row_idx=4, rom_address=39 stable throughout; transfer on first ready cycle; row 5 = 0x43 follows.
- Start ignored: pulse start while busy during row 2 -> exactly 16 rows delivered and a single done pulse.
- Mid-sweep reset: assert rst_n during FETCH of row 6 -> outputs 0 asynchronously; next start delivers row 0 first, with the full 16-row sequence intact.
- Mirror (GLYPH_ROW_MIRROR_EN defined): same sweep -> row 5 = 0xC2, row 3 = 0x3C, row 4 = 0x66.
